// File: rtl/cpu_debug_ctrl_pkg.sv
// Shared types and defaults for the MIPS8 run-control / debug-readout unit.
package cpu_debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESTART = 3'd1,
    ST_RUN     = 3'd2,
    ST_STEP    = 3'd3,
    ST_HALT    = 3'd4,
    ST_DONE    = 3'd5
  } dbg_state_e;

  localparam logic DBG_SEL_RF = 1'b0;
  localparam logic DBG_SEL_DM = 1'b1;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_RF_AW    = 2;
  localparam int DEF_DM_AW    = 4;
  localparam int DEF_PC_W     = 8;
  localparam int DEF_READ_LAT = 1;
  localparam int DEF_CYC_W    = 16;

endpackage

// File: rtl/cpu_debug_ctrl_if.sv
// Readout request/response bundle: requester (master) asks, cpu_debug_ctrl (slave) answers.
interface cpu_debug_ctrl_if import cpu_debug_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DM_AW  = DEF_DM_AW
);
  logic              rd_req;
  logic              rd_is_dm;
  logic [DM_AW-1:0]  rd_addr;
  logic              rd_busy;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_req, rd_is_dm, rd_addr, input rd_busy, rd_valid, rd_data);
  modport slave  (input rd_req, rd_is_dm, rd_addr, output rd_busy, rd_valid, rd_data);
endinterface

// File: rtl/cpu_debug_ctrl_readout.sv
// Debug readout sequencer: latches a request, drives the CPU debug address,
// waits READ_LAT cycles and captures the selected RF/DM word.
module dbg_readout import cpu_debug_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RF_AW    = DEF_RF_AW,
  parameter int DM_AW    = DEF_DM_AW,
  parameter int READ_LAT = DEF_READ_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  cpu_debug_ctrl_if.slave   rd_if,
  output logic [RF_AW-1:0]  dbg_rf_addr_o,
  output logic [DM_AW-1:0]  dbg_dm_addr_o,
  input  logic [DATA_W-1:0] dbg_rf_data_i,
  input  logic [DATA_W-1:0] dbg_dm_data_i
);
  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LAT - 1);

  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              sel_q, sel_d;
  logic [DM_AW-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Capture happens in the last busy cycle, so a request in the valid cycle is free to start.
  always_comb begin
    busy_d  = busy_q;
    valid_d = 1'b0;
    sel_d   = sel_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    if (busy_q) begin
      if (cnt_q == '0) begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
        data_d  = (sel_q == DBG_SEL_DM) ? dbg_dm_data_i : dbg_rf_data_i;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (rd_if.rd_req) begin
      busy_d = 1'b1;
      sel_d  = rd_if.rd_is_dm;
      addr_d = rd_if.rd_addr;
      cnt_d  = CNT_INIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      sel_q   <= DBG_SEL_RF;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign rd_if.rd_busy  = busy_q;
  assign rd_if.rd_valid = valid_q;
  assign rd_if.rd_data  = data_q;
  assign dbg_rf_addr_o  = addr_q[RF_AW-1:0];
  assign dbg_dm_addr_o  = addr_q;
endmodule

// File: rtl/cpu_debug_ctrl.sv
// Run-control FSM, PC breakpoint and executed-cycle counter for the MIPS8 core.
// Breakpoint logic is built only when DBG_BREAKPOINT_EN is defined.
module cpu_debug_ctrl import cpu_debug_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RF_AW    = DEF_RF_AW,
  parameter int DM_AW    = DEF_DM_AW,
  parameter int PC_W     = DEF_PC_W,
  parameter int READ_LAT = DEF_READ_LAT,
  parameter int CYC_W    = DEF_CYC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              step_i,
  input  logic              halt_req_i,
  input  logic              cpu_done_i,
  input  logic [PC_W-1:0]   cpu_pc_i,
  input  logic              bp_en_i,
  input  logic [PC_W-1:0]   bp_addr_i,
  output logic              cpu_run_en_o,
  output logic              cpu_restart_o,
  output logic              stopped_o,
  cpu_debug_ctrl_if.slave   rd_if,
  output logic [RF_AW-1:0]  dbg_rf_addr_o,
  output logic [DM_AW-1:0]  dbg_dm_addr_o,
  input  logic [DATA_W-1:0] dbg_rf_data_i,
  input  logic [DATA_W-1:0] dbg_dm_data_i,
  output logic [CYC_W-1:0]  cycle_count_o
);
  dbg_state_e       state_q, state_d;
  logic             start_q, step_q;
  logic             start_edge, step_edge;
  logic             bp_hit, run_en;
  logic [CYC_W-1:0] cyc_q, cyc_d;

  assign start_edge = start_i & ~start_q;
  assign step_edge  = step_i & ~step_q;

`ifdef DBG_BREAKPOINT_EN
  logic bp_skip_q, bp_skip_d;

  assign bp_hit = (state_q == ST_RUN) & bp_en_i & (cpu_pc_i == bp_addr_i) & ~bp_skip_q;

  // Resuming from HALT must execute the instruction that tripped the breakpoint.
  always_comb begin
    bp_skip_d = bp_skip_q;
    if (state_q == ST_HALT && state_d == ST_RUN) bp_skip_d = 1'b1;
    else if (state_q == ST_RUN)                  bp_skip_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bp_skip_q <= 1'b0;
    else        bp_skip_q <= bp_skip_d;
  end
`else
  logic unused_bp;
  assign unused_bp = ^{bp_en_i, bp_addr_i, cpu_pc_i};
  assign bp_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      step_q  <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_i;
      step_q  <= step_i;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (!halt_req_i) begin
        if (start_edge)     state_d = ST_RESTART;
        else if (step_edge) state_d = ST_STEP;
      end
      ST_RESTART: state_d = ST_RUN;
      ST_RUN: begin
        if (cpu_done_i)                state_d = ST_DONE;
        else if (halt_req_i || bp_hit) state_d = ST_HALT;
      end
      ST_STEP: state_d = cpu_done_i ? ST_DONE : ST_HALT;
      ST_HALT: if (!halt_req_i) begin
        if (start_edge)     state_d = ST_RUN;
        else if (step_edge) state_d = ST_STEP;
      end
      ST_DONE: if (start_edge) state_d = ST_RESTART;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    run_en        = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !bp_hit;
    cpu_restart_o = (state_q == ST_RESTART);
    stopped_o     = (state_q == ST_HALT) || (state_q == ST_DONE);
  end

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == ST_RESTART)  cyc_d = '0;
    else if (run_en && ~&cyc_q) cyc_d = cyc_q + 1'b1;
  end

  assign cpu_run_en_o  = run_en;
  assign cycle_count_o = cyc_q;

  dbg_readout #(
    .DATA_W   (DATA_W),
    .RF_AW    (RF_AW),
    .DM_AW    (DM_AW),
    .READ_LAT (READ_LAT)
  ) u_readout (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_if         (rd_if),
    .dbg_rf_addr_o (dbg_rf_addr_o),
    .dbg_dm_addr_o (dbg_dm_addr_o),
    .dbg_rf_data_i (dbg_rf_data_i),
    .dbg_dm_data_i (dbg_dm_data_i)
  );
endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Self-checking bench for cpu_debug_ctrl: directed table, corner sequences and a
// randomized run against a behavioural model. Breakpoint checks follow DBG_BREAKPOINT_EN.
module tb_cpu_debug_ctrl;
  localparam int DATA_W = 8, RF_AW = 2, DM_AW = 4, PC_W = 8, READ_LAT = 2, CYC_W = 16;
`ifdef DBG_BREAKPOINT_EN
  localparam bit BP_ON = 1'b1;
`else
  localparam bit BP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start, step, halt_req, cpu_done, bp_en;
  logic [PC_W-1:0] cpu_pc, bp_addr;
  logic run_en, restart, stopped;
  logic [RF_AW-1:0] dbg_rf_addr;
  logic [DM_AW-1:0] dbg_dm_addr;
  logic [DATA_W-1:0] dbg_rf_data, dbg_dm_data;
  logic [CYC_W-1:0] cycle_count;

  cpu_debug_ctrl_if #(.DATA_W(DATA_W), .DM_AW(DM_AW)) rd_if ();

  cpu_debug_ctrl #(.DATA_W(DATA_W), .RF_AW(RF_AW), .DM_AW(DM_AW), .PC_W(PC_W),
                   .READ_LAT(READ_LAT), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .step_i(step), .halt_req_i(halt_req),
    .cpu_done_i(cpu_done), .cpu_pc_i(cpu_pc), .bp_en_i(bp_en), .bp_addr_i(bp_addr),
    .cpu_run_en_o(run_en), .cpu_restart_o(restart), .stopped_o(stopped), .rd_if(rd_if),
    .dbg_rf_addr_o(dbg_rf_addr), .dbg_dm_addr_o(dbg_dm_addr),
    .dbg_rf_data_i(dbg_rf_data), .dbg_dm_data_i(dbg_dm_data), .cycle_count_o(cycle_count));

  // CPU debug ports: data follows the address with a READ_LAT=2 pipeline (one register stage).
  logic [DATA_W-1:0] rf_mem [4];
  logic [DATA_W-1:0] dm_mem [16];
  logic [RF_AW-1:0] rf_hist = '0;
  logic [DM_AW-1:0] dm_hist = '0;
  always @(posedge clk) begin
    rf_hist <= dbg_rf_addr;
    dm_hist <= dbg_dm_addr;
  end
  assign dbg_rf_data = rf_mem[rf_hist];
  assign dbg_dm_data = dm_mem[dm_hist];

  // ---------------- behavioural model ----------------
  typedef enum int {P_IDLE, P_RESTART, P_RUN, P_STEP, P_HALT, P_DONE} phase_t;
  phase_t m_ph;
  bit m_ps, m_pt, m_skip, auto_pc, m_sel;
  int m_cnt, cyc, t_acc;
  logic [DM_AW-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_ph = P_IDLE; m_ps = 0; m_pt = 0; m_skip = 0; m_cnt = 0;
    cyc = 0; t_acc = -100; m_sel = 0; m_addr = '0; m_data = '0;
  endfunction

  function automatic bit m_bp_hit();
    return BP_ON && m_ph == P_RUN && bp_en === 1'b1 && cpu_pc == bp_addr && !m_skip;
  endfunction
  function automatic bit m_run();
    return (m_ph == P_RUN || m_ph == P_STEP) && !m_bp_hit();
  endfunction
  function automatic bit m_busy();
    return cyc > t_acc && cyc <= t_acc + READ_LAT;
  endfunction
  function automatic bit m_valid();
    return cyc == t_acc + READ_LAT + 1;
  endfunction
  function automatic logic [DATA_W-1:0] m_mem();
    logic [RF_AW-1:0] ra;
    ra = m_addr[RF_AW-1:0];
    return m_sel ? dm_mem[m_addr] : rf_mem[ra];
  endfunction

  task automatic model_check();
    chk("run_en", run_en, m_run());
    chk("restart", restart, m_ph == P_RESTART);
    chk("stopped", stopped, m_ph == P_HALT || m_ph == P_DONE);
    chk("cycle_count", cycle_count, m_cnt);
    chk("rd_busy", rd_if.rd_busy, m_busy());
    chk("rd_valid", rd_if.rd_valid, m_valid());
    chk("rd_data", rd_if.rd_data, m_valid() ? m_mem() : m_data);
    chk("dbg_dm_addr", dbg_dm_addr, m_addr);
    chk("dbg_rf_addr", dbg_rf_addr, m_addr[RF_AW-1:0]);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Check against the model, advance it by one clock, then step the DUT.
  task automatic advance();
    bit se, te, hit, run;
    phase_t nx;
    logic [PC_W-1:0] npc;
    model_check();
    se = (start === 1'b1) && !m_ps;
    te = (step === 1'b1) && !m_pt;
    hit = m_bp_hit();
    run = m_run();
    if (m_valid()) m_data = m_mem();
    if (!m_busy() && rd_if.rd_req === 1'b1) begin
      t_acc = cyc; m_sel = rd_if.rd_is_dm; m_addr = rd_if.rd_addr;
    end
    nx = m_ph;
    case (m_ph)
      P_IDLE:    if (!halt_req) begin if (se) nx = P_RESTART; else if (te) nx = P_STEP; end
      P_RESTART: begin m_cnt = 0; nx = P_RUN; end
      P_RUN: begin
        if (cpu_done) nx = P_DONE;
        else if (halt_req || hit) nx = P_HALT;
        if (run) m_skip = 0;
      end
      P_STEP:    nx = cpu_done ? P_DONE : P_HALT;
      P_HALT:    if (!halt_req) begin
        if (se) begin nx = P_RUN; m_skip = 1; end
        else if (te) nx = P_STEP;
      end
      P_DONE:    if (se) nx = P_RESTART;
      default:   nx = P_IDLE;
    endcase
    if (run && m_cnt < 65535) m_cnt++;
    npc = cpu_pc;
    if (auto_pc) begin
      if (m_ph == P_RESTART) npc = '0;
      else if (run) npc = (cpu_pc + 8'd1) & 8'h0F;
    end
    m_ph = nx; m_ps = start; m_pt = step; cyc++;
    @(posedge clk); #1;
    cpu_pc = npc;
  endtask

  task automatic cycle1();
    settle(); advance();
  endtask

  task automatic do_reset();
    rst_n = 0; start = 0; step = 0; halt_req = 0; cpu_done = 0; bp_en = 0; bp_addr = '0;
    cpu_pc = '0; rd_if.rd_req = 0; rd_if.rd_is_dm = 0; rd_if.rd_addr = '0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit st, sp, hr, dn;
    bit e_run, e_rst, e_stop;
    int e_cnt;
  } vec_t;
  vec_t tbl[$];

  initial begin
    for (int i = 0; i < 4; i++)  rf_mem[i] = 8'(8'hA0 + i * 5);
    for (int i = 0; i < 16; i++) dm_mem[i] = 8'(i * 17 + 3);
    dm_mem[10] = 8'h3C;
    auto_pc = 1;

    // start step halt done | run restart stopped count
    tbl.push_back('{0,0,0,0, 0,0,0,0}); tbl.push_back('{0,1,0,0, 0,0,0,0});
    tbl.push_back('{0,1,0,0, 1,0,0,0}); tbl.push_back('{0,0,0,0, 0,0,1,1});
    tbl.push_back('{0,1,0,0, 0,0,1,1}); tbl.push_back('{0,0,0,0, 1,0,0,1});
    tbl.push_back('{0,1,0,0, 0,0,1,2}); tbl.push_back('{0,1,0,0, 1,0,0,2});
    tbl.push_back('{0,1,0,0, 0,0,1,3}); tbl.push_back('{0,1,0,0, 0,0,1,3});
    tbl.push_back('{1,0,1,0, 0,0,1,3}); tbl.push_back('{1,0,1,0, 0,0,1,3});
    tbl.push_back('{1,0,0,0, 0,0,1,3}); tbl.push_back('{0,0,0,0, 0,0,1,3});
    tbl.push_back('{1,0,0,0, 0,0,1,3}); tbl.push_back('{1,0,0,0, 1,0,0,3});
    tbl.push_back('{1,0,0,1, 1,0,0,4}); tbl.push_back('{1,0,0,0, 0,0,1,5});
    tbl.push_back('{0,0,0,0, 0,0,1,5}); tbl.push_back('{1,0,0,0, 0,0,1,5});
    tbl.push_back('{1,0,0,0, 0,1,0,5}); tbl.push_back('{1,0,0,0, 1,0,0,0});
    tbl.push_back('{1,0,0,0, 1,0,0,1}); tbl.push_back('{1,0,1,0, 1,0,0,2});
    tbl.push_back('{0,0,0,0, 0,0,1,3}); tbl.push_back('{0,1,1,0, 0,0,1,3});
    tbl.push_back('{0,1,0,0, 0,0,1,3});

    // Reset state and directed run-control table
    do_reset();
    settle();
    chk("reset_run_en", run_en, 0); chk("reset_stopped", stopped, 0);
    chk("reset_count", cycle_count, 0); chk("reset_rd_data", rd_if.rd_data, 0);
    advance();
    foreach (tbl[i]) begin
      start = tbl[i].st; step = tbl[i].sp; halt_req = tbl[i].hr; cpu_done = tbl[i].dn;
      settle();
      chk($sformatf("tbl%0d_run_en", i), run_en, tbl[i].e_run);
      chk($sformatf("tbl%0d_restart", i), restart, tbl[i].e_rst);
      chk($sformatf("tbl%0d_stopped", i), stopped, tbl[i].e_stop);
      chk($sformatf("tbl%0d_count", i), cycle_count, tbl[i].e_cnt);
      advance();
    end

    // Breakpoint at PC 05, then resume past it
    do_reset();
    auto_pc = 0; bp_en = 1; bp_addr = 8'h05; start = 1;
    cycle1();
    settle(); chk("bp_restart", restart, 1); advance();
    for (int c = 2; c <= 6; c++) begin cpu_pc = 8'(c - 2); cycle1(); end
    cpu_pc = 8'h05;
    settle(); chk("bp_hit_run_en", run_en, BP_ON ? 0 : 1); advance();
    start = 0;
    settle(); chk("bp_halted", stopped, BP_ON ? 1 : 0); advance();
    start = 1; cycle1();
    settle(); chk("bp_resume_run_en", run_en, 1); advance();
    cpu_pc = 8'h06;
    settle(); chk("bp_past_run_en", run_en, 1); chk("bp_past_stopped", stopped, 0);
    chk("bp_count", cycle_count, BP_ON ? 6 : 9); advance();
    auto_pc = 1;

    // Readout with READ_LAT=2; request while busy is ignored
    do_reset();
    rd_if.rd_req = 1; rd_if.rd_is_dm = 1; rd_if.rd_addr = 4'hA;
    settle(); chk("rd0_busy", rd_if.rd_busy, 0); advance();
    rd_if.rd_is_dm = 0; rd_if.rd_addr = 4'h3;
    settle(); chk("rd1_busy", rd_if.rd_busy, 1); chk("rd1_dm_addr", dbg_dm_addr, 4'hA); advance();
    rd_if.rd_req = 0;
    settle(); chk("rd2_valid", rd_if.rd_valid, 0); advance();
    settle(); chk("rd3_valid", rd_if.rd_valid, 1); chk("rd3_busy", rd_if.rd_busy, 0);
    chk("rd3_data", rd_if.rd_data, 8'h3C); advance();
    settle(); chk("rd4_valid", rd_if.rd_valid, 0); chk("rd4_data", rd_if.rd_data, 8'h3C); advance();
    settle(); chk("rd5_valid", rd_if.rd_valid, 0); advance();

    // Asynchronous reset while running and mid-readout
    start = 1; repeat (5) cycle1();
    rd_if.rd_req = 1; rd_if.rd_is_dm = 1; rd_if.rd_addr = 4'h7; cycle1();
    rd_if.rd_req = 0;
    rst_n = 0; #2;
    chk("arst_run_en", run_en, 0); chk("arst_restart", restart, 0); chk("arst_stopped", stopped, 0);
    chk("arst_busy", rd_if.rd_busy, 0); chk("arst_valid", rd_if.rd_valid, 0);
    chk("arst_data", rd_if.rd_data, 0); chk("arst_dm_addr", dbg_dm_addr, 0);
    chk("arst_rf_addr", dbg_rf_addr, 0); chk("arst_count", cycle_count, 0);
    m_reset(); start = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin settle(); chk("arst_no_valid", rd_if.rd_valid, 0); advance(); end

    // Saturating counter; halt_req and cpu_done together go to DONE
    do_reset();
    start = 1;
    repeat (65540) cycle1();
    settle(); chk("sat_count", cycle_count, 16'hFFFF); advance();
    halt_req = 1; cpu_done = 1;
    settle(); chk("hd_run_en", run_en, 1); advance();
    halt_req = 0; cpu_done = 0; start = 0;
    settle(); chk("hd_stopped", stopped, 1); chk("hd_run_en_off", run_en, 0);
    chk("hd_restart", restart, 0); chk("hd_count", cycle_count, 16'hFFFF); advance();
    start = 1; cycle1();
    settle(); chk("rs_restart", restart, 1); advance();
    settle(); chk("rs_count", cycle_count, 0); chk("rs_run_en", run_en, 1); advance();

    // Randomized run against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) start = ~start;
      if ($urandom_range(0, 3) == 0) step = ~step;
      if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
      cpu_done = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 49) == 0) begin
        bp_en = 1'($urandom_range(0, 1));
        bp_addr = 8'($urandom_range(0, 15));
      end
      rd_if.rd_req = ($urandom_range(0, 2) == 0);
      rd_if.rd_is_dm = 1'($urandom_range(0, 1));
      rd_if.rd_addr = 4'($urandom_range(0, 15));
      cycle1();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
